tm1638_responder: RTL

//   Device-side (responder) end of the TM1638 3-wire serial link: decodes STB/CLK/DIO frames from a
//   TM1638 master (tm1638_board_controller or external MCU), holds the 16-byte display RAM, exposes
//   per-digit hgfedcba segments, LEDs and display control, and returns the 32-bit key scan on read.

---
 rtl/tm1638_responder.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/tm1638_responder.sv
// TM1638 device-side responder: decodes STB/CLK/DIO frames, holds the 16-byte display RAM,
// exports segments/LEDs/display control and returns the snapshotted key scan on a read command.
module tm1638_responder #(
  parameter int unsigned w_digit     = 8,
  parameter int unsigned w_led       = 8,
  parameter int unsigned w_key       = 8,
  parameter int unsigned sync_stages = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sio_clk,
  input  logic                 sio_stb,
  input  logic                 sio_data_in,
  output logic                 sio_data_out,
  output logic                 sio_data_oe,
  input  logic [w_key-1:0]     keys,
  output logic [w_digit*8-1:0] hgfedcba,
  output logic [w_led-1:0]     ledr,
  output logic                 display_on,
  output logic [2:0]           brightness,
  output logic                 frame_done,
  output logic                 cmd_err
);

  typedef enum logic [2:0] {
    StWaitIdle, StIdle, StCmd, StWrData, StRdKeys, StIgnore
  } state_e;

  // Chains reset low so a frame already in progress at reset cannot fake an STB fall.
  logic [sync_stages-1:0] clk_sync_q, stb_sync_q, dat_sync_q;
  logic                   clk_prev_q, stb_prev_q;
  logic                   clk_s, stb_s, dat_s;
  logic                   clk_rise, clk_fall, stb_rise, stb_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= '0;
      stb_sync_q <= '0;
      dat_sync_q <= '0;
      clk_prev_q <= 1'b0;
      stb_prev_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[sync_stages-2:0], sio_clk};
      stb_sync_q <= {stb_sync_q[sync_stages-2:0], sio_stb};
      dat_sync_q <= {dat_sync_q[sync_stages-2:0], sio_data_in};
      clk_prev_q <= clk_s;
      stb_prev_q <= stb_s;
    end
  end

  assign clk_s    = clk_sync_q[sync_stages-1];
  assign stb_s    = stb_sync_q[sync_stages-1];
  assign dat_s    = dat_sync_q[sync_stages-1];
  assign clk_rise = clk_s & ~clk_prev_q;
  assign clk_fall = ~clk_s & clk_prev_q;
  assign stb_rise = stb_s & ~stb_prev_q;
  assign stb_fall = ~stb_s & stb_prev_q;

  state_e          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [5:0]      rd_cnt_q, rd_cnt_d;
  logic [3:0]      addr_q, addr_d;
  logic            mode_fixed_q, mode_fixed_d;
  logic            display_on_q, display_on_d;
  logic [2:0]      bright_q, bright_d;
  logic [7:0]      key_snap_q, key_snap_d;
  logic            oe_q, oe_d;
  logic            dout_q, dout_d;
  logic            frame_done_q, frame_done_d;
  logic            cmd_err_q, cmd_err_d;
  logic [15:0][7:0] ram_q;
  logic            ram_we;

  logic [7:0]  byte_full;
  logic        byte_done;
  logic [7:0]  keys_pad;
  logic [31:0] rd_word;

  assign byte_full = {dat_s, shift_q[7:1]};
  assign byte_done = clk_rise && (bit_cnt_q == 3'd7);
  assign keys_pad  = 8'(keys);

  // Read byte i carries key[i] in bit0 and key[i+4] in bit4.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 4; i++) begin
      rd_word[8*i]     = key_snap_q[i];
      rd_word[8*i + 4] = key_snap_q[i+4];
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    addr_d       = addr_q;
    mode_fixed_d = mode_fixed_q;
    display_on_d = display_on_q;
    bright_d     = bright_q;
    key_snap_d   = key_snap_q;
    oe_d         = oe_q;
    dout_d       = dout_q;
    frame_done_d = 1'b0;
    cmd_err_d    = 1'b0;
    ram_we       = 1'b0;

    case (state_q)
      StWaitIdle: if (stb_s) state_d = StIdle;
      StIdle: begin
        if (stb_fall) begin
          state_d   = StCmd;
          bit_cnt_d = '0;
        end
      end
      default: begin
        if (stb_rise) begin
          // STB rise beats any same-cycle CLK edge and drops a partial byte.
          state_d      = StIdle;
          oe_d         = 1'b0;
          dout_d       = 1'b0;
          bit_cnt_d    = '0;
          frame_done_d = 1'b1;
        end else begin
          if (clk_rise && (state_q == StCmd || state_q == StWrData)) begin
            shift_d   = byte_full;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          case (state_q)
            StCmd: begin
              if (byte_done) begin
                case (byte_full[7:6])
                  2'b01: begin
                    mode_fixed_d = byte_full[2];
                    if (byte_full[1:0] == 2'b10) begin
                      state_d    = StRdKeys;
                      key_snap_d = keys_pad;
                      rd_cnt_d   = '0;
                    end else begin
                      state_d = StIgnore;
                    end
                  end
                  2'b10: begin
                    display_on_d = byte_full[3];
                    bright_d     = byte_full[2:0];
                    state_d      = StIgnore;
                  end
                  2'b11: begin
                    addr_d  = byte_full[3:0];
                    state_d = StWrData;
                  end
                  default: begin
                    cmd_err_d = 1'b1;
                    state_d   = StIgnore;
                  end
                endcase
              end
            end
            StWrData: begin
              if (byte_done) begin
                ram_we = 1'b1;
                if (!mode_fixed_q) addr_d = addr_q + 4'd1;
              end
            end
            StRdKeys: begin
              if (clk_fall && rd_cnt_q < 6'd32) begin
                oe_d     = 1'b1;
                dout_d   = rd_word[rd_cnt_q[4:0]];
                rd_cnt_d = rd_cnt_q + 6'd1;
              end else if (clk_rise && rd_cnt_q == 6'd32) begin
                oe_d    = 1'b0;
                dout_d  = 1'b0;
                state_d = StIgnore;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StWaitIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      rd_cnt_q     <= '0;
      addr_q       <= '0;
      mode_fixed_q <= 1'b0;
      display_on_q <= 1'b0;
      bright_q     <= '0;
      key_snap_q   <= '0;
      oe_q         <= 1'b0;
      dout_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cmd_err_q    <= 1'b0;
      ram_q        <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      addr_q       <= addr_d;
      mode_fixed_q <= mode_fixed_d;
      display_on_q <= display_on_d;
      bright_q     <= bright_d;
      key_snap_q   <= key_snap_d;
      oe_q         <= oe_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
      cmd_err_q    <= cmd_err_d;
      if (ram_we) ram_q[addr_q] <= byte_full;
    end
  end

  for (genvar d = 0; d < w_digit; d++) begin : g_digit
    assign hgfedcba[8*d +: 8] = ram_q[2*d];
  end
  for (genvar d = 0; d < w_led; d++) begin : g_led
    assign ledr[d] = ram_q[2*d+1][0];
  end

  // Odd-byte upper bits and any non-exported bytes are storage only.
  logic unused_ram;
  assign unused_ram = ^ram_q;

  assign sio_data_out = dout_q;
  assign sio_data_oe  = oe_q;
  assign display_on   = display_on_q;
  assign brightness   = bright_q;
  assign frame_done   = frame_done_q;
  assign cmd_err      = cmd_err_q;

endmodule
